// File: rtl/aes_state_loader_pkg.sv
// Shared types and constants for the AES state loader slice.
package aes_state_loader_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRun   = 2'd2
    } state_e;

    localparam int unsigned NumRoundsDefault = 10;

    localparam int unsigned WordW    = 32;
    localparam int unsigned NumWords = 4;
    localparam int unsigned BlockW   = WordW * NumWords;

    // Word index to block bit-slice LSB: idx 0 is the most significant word.
    localparam int unsigned WordLsb [NumWords] = '{96, 64, 32, 0};

endpackage

// File: rtl/aes_state_loader_if.sv
// Write/start/handshake bus between a block producer and the state loader.
interface aes_state_loader_if;
    import aes_state_loader_pkg::*;

    logic              wr_en;
    logic              wr_sel;
    logic [1:0]        wr_idx;
    logic [WordW-1:0]  wr_data;
    logic              start;
    logic              out_ready;
    logic [BlockW-1:0] state;
    logic [BlockW-1:0] key;
    logic              out_valid;
    logic              busy;
    logic [3:0]        round_cnt;
    logic              done;
    logic              err;

    // Producer / round-core side.
    modport master (
        output wr_en, wr_sel, wr_idx, wr_data, start, out_ready,
        input  state, key, out_valid, busy, round_cnt, done, err
    );

    // Loader side.
    modport slave (
        input  wr_en, wr_sel, wr_idx, wr_data, start, out_ready,
        output state, key, out_valid, busy, round_cnt, done, err
    );

endinterface

// File: rtl/aes_word_assembler.sv
// 4x32 word register file with a per-word valid mask, assembled into one 128-bit block.
module aes_word_assembler
    import aes_state_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_idx_i,
    input  logic [WordW-1:0]  wr_data_i,
    input  logic              clr_mask_i,
    output logic [BlockW-1:0] data_o,
    output logic [3:0]        mask_o,
    // Mask would be complete once this cycle's write lands.
    output logic              full_nxt_o
);

    logic [3:0] mask_q, mask_d;
    logic [3:0] wr_onehot;

    // Decode the write index into a one-hot word select.
    always_comb begin
        wr_onehot = 4'b0000;
        if (wr_en_i) begin
            wr_onehot = 4'b0001 << wr_idx_i;
        end
    end

    // Mask next-state: accumulate written words, clear on block hand-off.
    always_comb begin
        mask_d = mask_q | wr_onehot;
        if (clr_mask_i) begin
            mask_d = '0;
        end
    end

    // Mask register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    for (genvar w = 0; w < NumWords; w++) begin : g_word
        logic [WordW-1:0] word_q;

        // Word storage; data is kept across blocks until overwritten.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                word_q <= '0;
            end else if (wr_onehot[w]) begin
                word_q <= wr_data_i;
            end
        end

        assign data_o[WordLsb[w] +: WordW] = word_q;
    end

    assign mask_o     = mask_q;
    assign full_nxt_o = &(mask_q | wr_onehot);

endmodule

// File: rtl/aes_state_loader.sv
// Collects plaintext and key words, issues the block to the round core and tracks rounds.
module aes_state_loader
    import aes_state_loader_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NumRoundsDefault
) (
    input  logic                clk,
    input  logic                rst,
    aes_state_loader_if.slave   bus
);

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       err_q, err_d;

    logic       idle;
    logic       handshake;
    logic       pt_we, key_we;
    logic       pt_full_nxt, key_full_nxt;
    logic [3:0] pt_mask, key_mask;

    assign idle      = (state_q == StIdle);
    assign handshake = (state_q == StIssue) && bus.out_ready;
    assign pt_we     = idle && bus.wr_en && !bus.wr_sel;
    assign key_we    = idle && bus.wr_en && bus.wr_sel;

    aes_word_assembler u_pt (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (pt_we),
        .wr_idx_i   (bus.wr_idx),
        .wr_data_i  (bus.wr_data),
        .clr_mask_i (handshake),
        .data_o     (bus.state),
        .mask_o     (pt_mask),
        .full_nxt_o (pt_full_nxt)
    );

    aes_word_assembler u_key (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (key_we),
        .wr_idx_i   (bus.wr_idx),
        .wr_data_i  (bus.wr_data),
        .clr_mask_i (handshake),
        .data_o     (bus.key),
        .mask_o     (key_mask),
        .full_nxt_o (key_full_nxt)
    );

    // Next-state, round counter and error detection.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Start sees the masks including a write in the same cycle.
                if (bus.start) begin
                    if (pt_full_nxt && key_full_nxt) begin
                        state_d = StIssue;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                err_d = bus.wr_en || bus.start;
                if (bus.out_ready) begin
                    state_d = StRun;
                    round_d = 4'd1;
                end
            end
            StRun: begin
                err_d = bus.wr_en || bus.start;
                if (round_q == LastRound) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                round_d = 4'd0;
            end
        endcase
    end

    // State, round counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = (state_q == StIssue);
    assign bus.busy      = !idle;
    assign bus.round_cnt = round_q;
    assign bus.done      = (state_q == StRun) && (round_q == LastRound);
    assign bus.err       = err_q;

    // Masks are only consumed through the look-ahead full flags.
    logic unused_masks;
    assign unused_masks = ^{pt_mask, key_mask};

endmodule
